draw_sequencer: RTL and testbench

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

---
 rtl/draw_sequencer.sv | 157 +++++++++++++++
 tb/tb_draw_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// Baccarat dealing sequencer: issues card-load strobes and latches the win lights.
// Define DRAW_RULES_EN to enable the third-card rules; otherwise every round compares after two cards each.
module draw_sequencer (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DEAL_P1 = 4'd1,
    DEAL_D1 = 4'd2,
    DEAL_P2 = 4'd3,
    DEAL_D2 = 4'd4,
    EVAL_P  = 4'd5,
    DEAL_P3 = 4'd6,
    EVAL_D  = 4'd7,
    DEAL_D3 = 4'd8,
    COMPARE = 4'd9,
    DONE    = 4'd10
  } state_e;

  state_e state_q, state_d;
  logic   playerWin_q, playerWin_d;
  logic   dealerWin_q, dealerWin_d;
  logic   goThird;
  logic [3:0] pSat, dSat;

  // Out-of-range hand totals are clamped to the best legal total.
  assign pSat = (pscore > 4'd9) ? 4'd9 : pscore;
  assign dSat = (dscore > 4'd9) ? 4'd9 : dscore;

`ifdef DRAW_RULES_EN
  logic       playerDrew_q, playerDrew_d;
  logic [3:0] p3Value;
  logic       dealerDraws;

  // Tens and face cards count zero toward the dealer's third-card decision.
  assign p3Value = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

  always_comb begin
    dealerDraws = 1'b0;
    if (playerDrew_q) begin
      case (dSat)
        4'd0, 4'd1, 4'd2: dealerDraws = 1'b1;
        4'd3:             dealerDraws = (p3Value != 4'd8);
        4'd4:             dealerDraws = (p3Value >= 4'd2) && (p3Value <= 4'd7);
        4'd5:             dealerDraws = (p3Value >= 4'd4) && (p3Value <= 4'd7);
        4'd6:             dealerDraws = (p3Value >= 4'd6) && (p3Value <= 4'd7);
        default:          dealerDraws = 1'b0;
      endcase
    end else begin
      dealerDraws = (dSat <= 4'd5);
    end
  end

  assign goThird = 1'b1;
`else
  logic unused_pcard3;
  assign unused_pcard3 = ^pcard3;
  assign goThird = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    playerWin_d = playerWin_q;
    dealerWin_d = dealerWin_q;
`ifdef DRAW_RULES_EN
    playerDrew_d = playerDrew_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = DEAL_P1;
`ifdef DRAW_RULES_EN
        playerDrew_d = 1'b0;
`endif
      end
      DEAL_P1: state_d = DEAL_D1;
      DEAL_D1: state_d = DEAL_P2;
      DEAL_P2: state_d = DEAL_D2;
      DEAL_D2: state_d = EVAL_P;
      EVAL_P: begin
        if (!goThird || pSat >= 4'd8 || dSat >= 4'd8) begin
          state_d = COMPARE;
        end else if (pSat <= 4'd5) begin
          state_d = DEAL_P3;
        end else begin
          state_d = EVAL_D;
        end
      end
`ifdef DRAW_RULES_EN
      DEAL_P3: begin
        state_d      = EVAL_D;
        playerDrew_d = 1'b1;
      end
      EVAL_D:  state_d = dealerDraws ? DEAL_D3 : COMPARE;
      DEAL_D3: state_d = COMPARE;
`endif
      COMPARE: begin
        playerWin_d = (pSat >= dSat);
        dealerWin_d = (dSat >= pSat);
        state_d     = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q     <= IDLE;
      playerWin_q <= 1'b0;
      dealerWin_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      playerWin_q <= playerWin_d;
      dealerWin_q <= dealerWin_d;
    end
  end

`ifdef DRAW_RULES_EN
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      playerDrew_q <= 1'b0;
    end else begin
      playerDrew_q <= playerDrew_d;
    end
  end
`endif

  // Strobes decode straight from the state so each lasts exactly one cycle.
  assign load_pcard1 = (state_q == DEAL_P1);
  assign load_dcard1 = (state_q == DEAL_D1);
  assign load_pcard2 = (state_q == DEAL_P2);
  assign load_dcard2 = (state_q == DEAL_D2);
`ifdef DRAW_RULES_EN
  assign load_pcard3 = (state_q == DEAL_P3);
  assign load_dcard3 = (state_q == DEAL_D3);
`else
  assign load_pcard3 = 1'b0;
  assign load_dcard3 = 1'b0;
`endif

  assign player_win_light = playerWin_q;
  assign dealer_win_light = dealerWin_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer; expected output vectors are queued per cycle and popped after each edge.
module tb_draw_sequencer;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic [3:0] pscore = 4'd0;
  logic [3:0] dscore = 4'd0;
  logic [3:0] pcard3 = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;
  logic [7:0] obs;

  localparam logic [7:0] NONE = 8'h00;
  localparam logic [7:0] SP1  = 8'h80;
  localparam logic [7:0] SD1  = 8'h40;
  localparam logic [7:0] SP2  = 8'h20;
  localparam logic [7:0] SD2  = 8'h10;
  localparam logic [7:0] SP3  = 8'h08;
  localparam logic [7:0] SD3  = 8'h04;
  localparam logic [7:0] LP   = 8'h02;
  localparam logic [7:0] LD   = 8'h01;
  localparam logic [7:0] LTIE = 8'h03;

  int testsRun = 0;
  int testsFailed = 0;
  logic [7:0] sbQ[$];

  draw_sequencer dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
  );

  assign obs = {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                load_pcard3, load_dcard3, player_win_light, dealer_win_light};

  always #5 slow_clock = ~slow_clock;

  task automatic checkOutput(input string tag);
    logic [7:0] e;
    e = sbQ.pop_front();
    testsRun++;
    assert (obs === e) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] exp, input string tag);
    sbQ.push_back(exp);
    @(posedge slow_clock);
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset(input string name);
    resetb = 1'b0;
    applyStimulus(NONE, {name, "_reset"});
    resetb = 1'b1;
  endtask

  task automatic dealFour(input string name);
    applyStimulus(SP1, {name, "_p1"});
    applyStimulus(SD1, {name, "_d1"});
    applyStimulus(SP2, {name, "_p2"});
    applyStimulus(SD2, {name, "_d2"});
    applyStimulus(NONE, {name, "_evalp"});
  endtask

  task automatic finishRound(input logic [7:0] lights, input string name);
    applyStimulus(lights, {name, "_done"});
    pscore = 4'd0;
    dscore = 4'd9;
    applyStimulus(lights, {name, "_hold1"});
    applyStimulus(lights, {name, "_hold2"});
  endtask

  initial begin
    // Natural 8 vs 3: straight to compare, player wins.
    pscore = 4'd8; dscore = 4'd3; pcard3 = 4'd0;
    doReset("nat");
    dealFour("nat");
    applyStimulus(NONE, "nat_compare");
    finishRound(LP, "nat");

    // Player 4, dealer 6, third card 7.
    pscore = 4'd4; dscore = 4'd6; pcard3 = 4'd7;
    doReset("p4d6");
    dealFour("p4d6");
`ifdef DRAW_RULES_EN
    applyStimulus(SP3, "p4d6_p3");
    applyStimulus(NONE, "p4d6_evald");
    applyStimulus(SD3, "p4d6_d3");
    pscore = 4'd1;
    applyStimulus(NONE, "p4d6_compare");
    finishRound(LD, "p4d6");
`else
    applyStimulus(NONE, "p4d6_compare");
    finishRound(LD, "p4d6");
`endif

    // Player 5 draws an 8, dealer 3 stands.
    pscore = 4'd5; dscore = 4'd3; pcard3 = 4'd8;
    doReset("p5d3");
    dealFour("p5d3");
`ifdef DRAW_RULES_EN
    applyStimulus(SP3, "p5d3_p3");
    pscore = 4'd3;
    applyStimulus(NONE, "p5d3_evald");
    applyStimulus(NONE, "p5d3_compare");
    finishRound(LTIE, "p5d3");
`else
    applyStimulus(NONE, "p5d3_compare");
    finishRound(LP, "p5d3");
`endif

    // Player 6 stands, dealer 5 draws to 6.
    pscore = 4'd6; dscore = 4'd5; pcard3 = 4'd0;
    doReset("p6d5");
    dealFour("p6d5");
`ifdef DRAW_RULES_EN
    applyStimulus(NONE, "p6d5_evald");
    applyStimulus(SD3, "p6d5_d3");
    dscore = 4'd6;
    applyStimulus(NONE, "p6d5_compare");
    finishRound(LTIE, "p6d5");
`else
    applyStimulus(NONE, "p6d5_compare");
    finishRound(LP, "p6d5");
`endif

    // Player 7 stands, dealer 6 stands.
    pscore = 4'd7; dscore = 4'd6; pcard3 = 4'd0;
    doReset("p7d6");
    dealFour("p7d6");
`ifdef DRAW_RULES_EN
    applyStimulus(NONE, "p7d6_evald");
`endif
    applyStimulus(NONE, "p7d6_compare");
    finishRound(LP, "p7d6");

    // Mid-round reset, then the deal restarts at the first player card.
    pscore = 4'd3; dscore = 4'd4; pcard3 = 4'd2;
    doReset("rst");
    dealFour("rst");
`ifdef DRAW_RULES_EN
    applyStimulus(SP3, "rst_p3");
`else
    applyStimulus(NONE, "rst_compare");
`endif
    resetb = 1'b0;
    applyStimulus(NONE, "rst_mid");
    resetb = 1'b1;
    applyStimulus(SP1, "rst_restart_p1");
    applyStimulus(SD1, "rst_restart_d1");

    // Score inputs above 9 clamp to 9.
    pscore = 4'd15; dscore = 4'd9; pcard3 = 4'd0;
    doReset("satp");
    dealFour("satp");
    applyStimulus(NONE, "satp_compare");
    finishRound(LTIE, "satp");

    pscore = 4'd9; dscore = 4'd12;
    doReset("satd");
    dealFour("satd");
    applyStimulus(NONE, "satd_compare");
    finishRound(LTIE, "satd");

    // Face card as player third card counts zero; dealer 3 draws.
    pscore = 4'd2; dscore = 4'd3; pcard3 = 4'd12;
    doReset("face");
    dealFour("face");
`ifdef DRAW_RULES_EN
    applyStimulus(SP3, "face_p3");
    applyStimulus(NONE, "face_evald");
    applyStimulus(SD3, "face_d3");
`endif
    applyStimulus(NONE, "face_compare");
    finishRound(LD, "face");

    // Player 2, dealer 1.
    pscore = 4'd2; dscore = 4'd1; pcard3 = 4'd0;
    doReset("p2d1");
    dealFour("p2d1");
`ifdef DRAW_RULES_EN
    applyStimulus(SP3, "p2d1_p3");
    applyStimulus(NONE, "p2d1_evald");
    applyStimulus(SD3, "p2d1_d3");
`endif
    applyStimulus(NONE, "p2d1_compare");
    finishRound(LP, "p2d1");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
